atten_spi_sequencer: RTL and testbench
======================================

// Module: atten_spi_sequencer
// PURPOSE
//  Upstream feeder for the attenuator SPI serializer on the ZCU111 daughter board.
//  Holds a shadow bank of per-channel attenuation settings and dirty flags.
//  On a go pulse, it formats one frame per dirty channel.
//  It drives each frame to the serializer via data_word/ld, then waits for the serializer's CS pulse before launching the next frame.
// PARAMETERS
//  DATA_W         32      width of data_word; equals serializer register width
//  FRAME_BITS     24      bits shifted per frame; bits [DATA_W-1:FRAME_BITS] driven 0
//  NUM_CH         4       number of attenuator channels (2..16)
//  ATTEN_W        7       attenuation code width
//  LD_CYCLES      4       clk cycles ld is held high per frame (>=1)
//  TIMEOUT_CYCLES 65535   watchdog limit per frame (used only with ATTEN_SEQ_TIMEOUT_EN)
// PORTS
//  clk        in   1                  system clock; same clock as the serializer
//  rst_n      in   1                  asynchronous active-low reset
//  wr_en      in   1                  write the shadow bank this cycle
//  wr_ch      in   $clog2(NUM_CH)     channel index for write
//  wr_atten   in   ATTEN_W            attenuation code for write
//  go         in   1                  start a sequence (pulse); ignored while busy
//  cs_in      in   1                  serializer CS output (high one phase at end of frame)
//  data_word  out  DATA_W             frame to serializer Data_Register
//  ld         out  1                  serializer load strobe
//  busy       out  1                  sequence in progress
//  done       out  1                  one-cycle pulse when a sequence completes
//  err        out  1                  sticky watchdog error; cleared by go or reset
// BEHAVIOUR
//  Reset: all outputs 0, all shadow values 0, all dirty flags 0, state IDLE, scan pointer 0.
//  Write: wr_en stores wr_atten at wr_ch and sets dirty[wr_ch] on the next edge; wr_ch>=NUM_CH is ignored.
//  Frame: data_word = (ch << ATTEN_W) | atten, zero-extended to DATA_W; LSB shifts first.
//  FSM:
//   IDLE   : busy=0. If go: clear err and go to SCAN.
//   SCAN   : search from ptr (wrapping) for a dirty channel; one channel examined per cycle.
//            Found ch: latch its frame into data_word, clear dirty[ch], set ptr=ch+1 (wrapping), go to LOAD.
//            If NUM_CH consecutive clean channels are seen: go to DONE.
//   LOAD   : ld=1 for exactly LD_CYCLES cycles; then ld=0 and go to WAIT_HI.
//   WAIT_HI: wait for cs_in==1, then go to WAIT_LO.
//   WAIT_LO: wait for cs_in==0, then go to SCAN.
//   DONE   : done=1 for one cycle, then go to IDLE.
//  busy=1 in every state except IDLE.
//  data_word stays stable from LOAD entry until the next SCAN latch.
//  Write vs launch: a write to the same channel in the cycle it is latched in SCAN wins.
//   Its dirty flag stays set, and the old value goes out in the current frame.
//  Writes during a sequence mark channels dirty; they are sent in this same sequence when the scan reaches them.
//  go while busy is ignored; go in the same cycle as DONE is ignored.
//  Latency: go to ld rise takes 2..NUM_CH+1 cycles.
//  With no dirty channels, go to done takes NUM_CH+1 cycles.
//  Reset mid-frame: the FSM returns to IDLE with ld=0 and all dirty flags cleared.
//   The serializer is not reset and finishes its frame on its own.
//   Software must wait at least one frame time before issuing go.
// CONFIGURATION
//  ATTEN_SEQ_TIMEOUT_EN defined:
//   - A cycle counter runs in WAIT_HI/WAIT_LO and resets on every state change.
//   - When it reaches TIMEOUT_CYCLES: set err=1, set dirty[ch] again for the aborted channel, go to DONE (done still pulses).
//  Not defined: no counter; the FSM waits indefinitely and err is tied 0.
// STRUCTURE
//  Package atten_seq_pkg: state enum (IDLE, SCAN, LOAD, WAIT_HI, WAIT_LO, DONE), and function build_frame(ch, atten).
//  Sub-module atten_shadow_bank: NUM_CH x ATTEN_W registers plus dirty flags, with a write port, read-by-index and clear-dirty port.
//   Write-wins priority lives here.
//  Top level: FSM, scan pointer, LD counter, optional watchdog.
// TESTING
//  The bench includes a behavioural serializer model: ld sampled, CS high for 21 clk at 24*42 clk after ld falls.
//  1. Write ch0=0x15 and ch2=0x7F, then go.
//     Expect data_word 0x00000015 then 0x0000017F, each with ld high for 4 cycles.
//     Then one done pulse, busy falls, and dirty flags are all 0.
//  2. go with the bank clean: expect no ld, and done asserts 5 cycles after go (NUM_CH=4).
//  3. Write ch1=0x40 during the ch0 frame's WAIT_HI: expect frames ch0, then ch1 (0x000000C0), then done.
//  4. Write ch3=0x01 in the same cycle SCAN latches ch3 (old 0x10).
//     Expect frame 0x00000190, then a second frame 0x00000181 in the same sequence.
//  5. With ATTEN_SEQ_TIMEOUT_EN and the model's CS disabled, send go with ch2 dirty.
//     Expect err=1 after 65535 cycles in WAIT_HI, dirty[2]=1 and a done pulse; the next go clears err.
//  6. Assert rst_n low during LOAD: ld=0, busy=0 and data_word=0 asynchronously; go after release restarts from ch0.

Source files
------------

// File: rtl/atten_spi_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// atten_seq_pkg
// Shared types and helpers for the attenuator SPI sequencer.
//   seq_state_t  : sequencer FSM states
//   build_frame  : packs {channel, attenuation} into the serializer frame layout
// -----------------------------------------------------------------------------
package atten_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SCAN    = 3'd1,
    LOAD    = 3'd2,
    WAIT_HI = 3'd3,
    WAIT_LO = 3'd4,
    DONE    = 3'd5
  } seq_state_t;

  // Frame layout: channel index sits directly above the attenuation code.
  // Wide fixed-size arguments keep the helper usable for any legal NUM_CH /
  // ATTEN_W; the caller slices the result down to its data width.
  function automatic logic [63:0] build_frame(input logic [31:0] ch,
                                              input logic [31:0] atten,
                                              input int          atten_w);
    return ({32'd0, ch} << atten_w) | {32'd0, atten};
  endfunction

endpackage

// File: rtl/atten_spi_sequencer_if.sv
// -----------------------------------------------------------------------------
// atten_spi_sequencer_if
// Bundles the host write/go port and the serializer handshake.
//   master : host + serializer side (drives wr_*, go, cs_in)
//   slave  : sequencer side (drives data_word, ld, busy, done, err)
// Parameters must match those of the attached atten_spi_sequencer.
// -----------------------------------------------------------------------------
interface atten_spi_sequencer_if #(
  parameter int DATA_W  = 32,
  parameter int NUM_CH  = 4,
  parameter int ATTEN_W = 7
);
  localparam int CH_W = $clog2(NUM_CH);

  logic               wr_en;
  logic [CH_W-1:0]    wr_ch;
  logic [ATTEN_W-1:0] wr_atten;
  logic               go;
  logic               cs_in;
  logic [DATA_W-1:0]  data_word;
  logic               ld;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    output wr_en, wr_ch, wr_atten, go, cs_in,
    input  data_word, ld, busy, done, err
  );

  modport slave (
    input  wr_en, wr_ch, wr_atten, go, cs_in,
    output data_word, ld, busy, done, err
  );

endinterface

// File: rtl/atten_spi_sequencer_shadow_bank.sv
// -----------------------------------------------------------------------------
// atten_shadow_bank
// Per-channel attenuation shadow registers with dirty flags.
//   clk, rst_n          : clock, async active-low reset
//   wr_en/wr_ch/wr_atten: host write; stores code and marks channel dirty
//   clr_en/clr_ch       : clear dirty flag (channel launched)
//   set_en/set_ch       : re-mark dirty flag (aborted frame)
//   rd_ch               : combinational read index
//   rd_atten/rd_dirty   : stored code and dirty flag at rd_ch
// A host write to the channel being cleared in the same cycle wins: its new
// code is stored and the channel stays dirty.
// -----------------------------------------------------------------------------
module atten_shadow_bank #(
  parameter int NUM_CH  = 4,
  parameter int ATTEN_W = 7,
  parameter int CH_W    = $clog2(NUM_CH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [CH_W-1:0]    wr_ch,
  input  logic [ATTEN_W-1:0] wr_atten,
  input  logic               clr_en,
  input  logic [CH_W-1:0]    clr_ch,
  input  logic               set_en,
  input  logic [CH_W-1:0]    set_ch,
  input  logic [CH_W-1:0]    rd_ch,
  output logic [ATTEN_W-1:0] rd_atten,
  output logic               rd_dirty
);

  logic [ATTEN_W-1:0] shadow [NUM_CH];
  logic [NUM_CH-1:0]  dirty;
  logic               wr_ok;

  assign wr_ok = wr_en && (int'(wr_ch) < NUM_CH);

  // NOTE: the shadow array is reset on purpose: software may issue go before
  // writing every channel, and a cleared bank guarantees a defined code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) shadow[i] <= '0;
      dirty <= '0;
    end else begin
      if (clr_en) dirty[clr_ch] <= 1'b0;
      if (set_en) dirty[set_ch] <= 1'b1;
      // Written last so a same-cycle host write overrides the clear.
      if (wr_ok) begin
        shadow[wr_ch] <= wr_atten;
        dirty[wr_ch]  <= 1'b1;
      end
    end
  end

  assign rd_atten = shadow[rd_ch];
  assign rd_dirty = dirty[rd_ch];

endmodule

// File: rtl/atten_spi_sequencer.sv
// -----------------------------------------------------------------------------
// atten_spi_sequencer
// Feeds the attenuator SPI serializer: on go, sends one frame per dirty
// channel (round-robin from the scan pointer), holding ld for LD_CYCLES and
// waiting for the serializer's CS pulse between frames.
//   clk, rst_n : clock (shared with serializer), async active-low reset
//   bus        : atten_spi_sequencer_if.slave (host write/go, serializer
//                data_word/ld/cs_in, status busy/done/err)
// Optional build macro ATTEN_SEQ_TIMEOUT_EN: adds a per-frame watchdog on the
// CS wait; on expiry err is set, the channel is re-marked dirty and the
// sequence ends with a done pulse. Without it err stays 0 and the wait is
// unbounded.
// -----------------------------------------------------------------------------
module atten_spi_sequencer
  import atten_seq_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int FRAME_BITS     = 24,
  parameter int NUM_CH         = 4,
  parameter int ATTEN_W        = 7,
  parameter int LD_CYCLES      = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input logic                  clk,
  input logic                  rst_n,
  atten_spi_sequencer_if.slave bus
);

  localparam int              CH_W    = $clog2(NUM_CH);
  localparam int              LD_W    = (LD_CYCLES > 1) ? $clog2(LD_CYCLES) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);
  localparam logic [LD_W-1:0] LD_LAST = LD_W'(LD_CYCLES - 1);

  seq_state_t         state;
  logic [CH_W-1:0]    ptr;
  logic [CH_W-1:0]    next_ptr;
  logic [CH_W-1:0]    clean_cnt;
  logic [CH_W-1:0]    cur_ch;
  logic [LD_W-1:0]    ld_cnt;
  logic [ATTEN_W-1:0] rd_atten;
  logic               rd_dirty;
  logic               clr_en;
  logic               wd_fire;
  logic [63:0]        frame_full;
  logic [DATA_W-1:0]  frame_next;

  assign next_ptr = (ptr == LAST_CH) ? '0 : ptr + 1'b1;
  assign clr_en   = (state == SCAN) && rd_dirty;

  atten_shadow_bank #(
    .NUM_CH  (NUM_CH),
    .ATTEN_W (ATTEN_W)
  ) u_bank (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (bus.wr_en),
    .wr_ch    (bus.wr_ch),
    .wr_atten (bus.wr_atten),
    .clr_en   (clr_en),
    .clr_ch   (ptr),
    .set_en   (wd_fire),
    .set_ch   (cur_ch),
    .rd_ch    (ptr),
    .rd_atten (rd_atten),
    .rd_dirty (rd_dirty)
  );

  // NOTE: every variable gets a default before the loop so no latch is
  // inferred for bits above FRAME_BITS.
  always_comb begin
    frame_full = build_frame(32'(ptr), 32'(rd_atten), ATTEN_W);
    frame_next = '0;
    for (int b = 0; b < FRAME_BITS; b++) frame_next[b] = frame_full[b];
  end

`ifdef ATTEN_SEQ_TIMEOUT_EN
  localparam int             WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt;
  logic            waiting;

  assign waiting = (state == WAIT_HI) || (state == WAIT_LO);
  assign wd_fire = waiting && (wd_cnt == WD_LAST);

  // Restarts on entry to each wait state; the only in-wait state change is
  // WAIT_HI -> WAIT_LO on cs_in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                           wd_cnt <= '0;
    else if (!waiting || wd_fire ||
             (state == WAIT_HI && bus.cs_in))              wd_cnt <= '0;
    else                                                  wd_cnt <= wd_cnt + 1'b1;
  end
`else
  assign wd_fire = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // branch below reads the pre-edge values of state, ptr and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= '0;
      clean_cnt     <= '0;
      cur_ch        <= '0;
      ld_cnt        <= '0;
      bus.data_word <= '0;
      bus.ld        <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.go) begin
            bus.err   <= 1'b0;
            bus.busy  <= 1'b1;
            clean_cnt <= '0;
            state     <= SCAN;
          end
        end
        SCAN: begin
          ptr <= next_ptr;
          if (rd_dirty) begin
            bus.data_word <= frame_next;
            bus.ld        <= 1'b1;
            ld_cnt        <= '0;
            clean_cnt     <= '0;
            cur_ch        <= ptr;
            state         <= LOAD;
          end else if (clean_cnt == LAST_CH) begin
            bus.done <= 1'b1;
            state    <= DONE;
          end else begin
            clean_cnt <= clean_cnt + 1'b1;
          end
        end
        LOAD: begin
          if (ld_cnt == LD_LAST) begin
            bus.ld <= 1'b0;
            state  <= WAIT_HI;
          end else begin
            ld_cnt <= ld_cnt + 1'b1;
          end
        end
        WAIT_HI, WAIT_LO: begin
          if (wd_fire) begin
            bus.err  <= 1'b1;
            bus.done <= 1'b1;
            state    <= DONE;
          end else if (state == WAIT_HI && bus.cs_in) begin
            state <= WAIT_LO;
          end else if (state == WAIT_LO && !bus.cs_in) begin
            state <= SCAN;
          end
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_atten_spi_sequencer.sv
// -----------------------------------------------------------------------------
// tb_atten_spi_sequencer
// Self-checking bench for atten_spi_sequencer with a behavioural serializer
// (CS high for 21 clk starting 24*42 clk after ld falls). Expected frames are
// queued when stimulus is driven and compared at each ld rise.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_atten_spi_sequencer;
  import atten_seq_pkg::*;

  localparam int DATA_W    = 32;
  localparam int NUM_CH    = 4;
  localparam int ATTEN_W   = 7;
  localparam int LD_CYCLES = 4;
  localparam int CS_START  = 24 * 42;
  localparam int CS_LEN    = 21;

  logic clk;
  logic rst_n;

  atten_spi_sequencer_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .ATTEN_W(ATTEN_W)) bus ();

  atten_spi_sequencer #(
    .DATA_W(DATA_W), .FRAME_BITS(24), .NUM_CH(NUM_CH), .ATTEN_W(ATTEN_W),
    .LD_CYCLES(LD_CYCLES), .TIMEOUT_CYCLES(65535)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] cur_exp  = '0;
  int          done_cnt = 0;
  int          ld_rises = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Behavioural serializer: not reset, finishes any frame it has started.
  bit cs_en    = 1'b1;
  int ser_cnt  = -1;
  bit ld_seen  = 1'b0;
  always @(negedge clk) begin
    if (ld_seen && !bus.ld)  ser_cnt = 0;
    else if (ser_cnt >= 0)   ser_cnt++;
    if (ser_cnt >= CS_START + CS_LEN) ser_cnt = -1;
    ld_seen    = bus.ld;
    bus.cs_in  = cs_en && (ser_cnt >= CS_START);
  end

  // Output monitor: frame scoreboard, ld width, data stability, done width.
  bit ld_prev = 1'b0;
  bit done_prev = 1'b0;
  int ld_width = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      ld_prev   = 1'b0;
      done_prev = 1'b0;
      ld_width  = 0;
    end else begin
      if (bus.ld && !ld_prev) begin
        ld_rises++;
        check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          cur_exp = exp_q.pop_front();
          check("frame_data", bus.data_word, cur_exp);
        end
        ld_width = 1;
      end else if (bus.ld && ld_prev) begin
        ld_width++;
        check("data_stable", bus.data_word, cur_exp);
      end else if (!bus.ld && ld_prev) begin
        check("ld_width", 32'(ld_width), 32'(LD_CYCLES));
      end
      if (bus.done) done_cnt++;
      if (bus.done && done_prev) check("done_pulse_width", 32'd2, 32'd1);
      ld_prev   = bus.ld;
      done_prev = bus.done;
    end
  end

  task automatic write_ch(input int ch, input int atten);
    @(posedge clk); #1;
    bus.wr_en    = 1'b1;
    bus.wr_ch    = 2'(ch);
    bus.wr_atten = 7'(atten);
    @(posedge clk); #1;
    bus.wr_en    = 1'b0;
  endtask

  task automatic go_pulse();
    @(posedge clk); #1 bus.go = 1'b1;
    @(posedge clk); #1 bus.go = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    int d0 = done_cnt;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < budget);
    check({tag, "_done_seen"}, 32'(bus.done), 32'd1);
    @(posedge clk); #1;
    check({tag, "_busy_low"}, 32'(bus.busy), 32'd0);
    check({tag, "_one_done"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_ld(input logic level, input int budget);
    int n = 0;
    while (bus.ld !== level && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("ld_wait", 32'(bus.ld), 32'(level));
  endtask

  task automatic apply_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data_word", bus.data_word, 32'h0);
    check("rst_ld",   32'(bus.ld),   32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err",  32'(bus.err),  32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    int r0;
    rst_n        = 1'b0;
    bus.wr_en    = 1'b0;
    bus.wr_ch    = '0;
    bus.wr_atten = '0;
    bus.go       = 1'b0;

    apply_reset();

    // 1: two dirty channels, sent in channel order.
    write_ch(0, 'h15); exp_q.push_back(32'h0000_0015);
    write_ch(2, 'h7F); exp_q.push_back(32'h0000_017F);
    go_pulse();
    wait_done("t1", 5000);
    check("t1_dirty_clear", 32'(dut.u_bank.dirty), 32'd0);

    // 2: clean bank, done NUM_CH+1 cycles after go, no ld.
    r0 = ld_rises;
    @(posedge clk); #1 bus.go = 1'b1;
    @(posedge clk); #1 bus.go = 1'b0;
    n = 1;
    while (!bus.done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("t2_go_to_done", 32'(n), 32'(NUM_CH + 1));
    check("t2_no_ld", 32'(ld_rises - r0), 32'd0);
    @(posedge clk); #1;
    check("t2_busy_low", 32'(bus.busy), 32'd0);

    // 3: write during the first frame's CS wait joins the same sequence.
    write_ch(0, 'h22); exp_q.push_back(32'h0000_0022);
    go_pulse();
    wait_ld(1'b1, 50);
    wait_ld(1'b0, 50);
    write_ch(1, 'h40); exp_q.push_back(32'h0000_00C0);
    wait_done("t3", 5000);

    // 4: write collides with the SCAN latch of ch3; old value goes first.
    apply_reset();
    write_ch(3, 'h10);
    exp_q.push_back(32'h0000_0190);
    exp_q.push_back(32'h0000_0181);
    @(posedge clk); #1 bus.go = 1'b1;
    @(posedge clk); #1 bus.go = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.wr_en = 1'b1; bus.wr_ch = 2'd3; bus.wr_atten = 7'h01;
    @(posedge clk); #1 bus.wr_en = 1'b0;
    wait_done("t4", 5000);

    // 6: asynchronous reset during LOAD; pointer restarts from ch0.
    write_ch(1, 'h11); exp_q.push_back(32'h0000_0091);
    go_pulse();
    wait_ld(1'b1, 50);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check("t6_ld_async",   32'(bus.ld),   32'd0);
    check("t6_busy_async", 32'(bus.busy), 32'd0);
    check("t6_data_async", bus.data_word, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("t6_dirty_clear", 32'(dut.u_bank.dirty), 32'd0);
    repeat (CS_START + CS_LEN + 20) @(posedge clk);
    write_ch(2, 'h03);
    write_ch(0, 'h04);
    exp_q.push_back(32'h0000_0004);
    exp_q.push_back(32'h0000_0103);
    go_pulse();
    wait_done("t6", 5000);

`ifdef ATTEN_SEQ_TIMEOUT_EN
    // 5: watchdog expiry with CS suppressed.
    cs_en = 1'b0;
    write_ch(2, 'h01); exp_q.push_back(32'h0000_0101);
    go_pulse();
    wait_done("t5", 70000);
    check("t5_err_set",   32'(bus.err), 32'd1);
    check("t5_redirty",   32'(dut.u_bank.dirty[2]), 32'd1);
    cs_en = 1'b1;
    exp_q.push_back(32'h0000_0101);
    go_pulse();
    check("t5_err_clear", 32'(bus.err), 32'd0);
    wait_done("t5b", 5000);
`endif

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
